// File: rtl/sc_rand_range_sampler.sv
// sc_rand_range_sampler
//   Rejection sampler fed by the 8-bit pseudo-random shifter stage. On a
//   request it draws one word per clock from rand_data_InBUS and keeps the
//   first word below RANGE. If MAX_TRIES draws are all rejected, it produces
//   a deterministic fallback instead: (rand - RANGE) when that is below
//   RANGE, otherwise RANGE-1. The result is offered with a valid/ack
//   handshake.
//
// Ports
//   SC_RegSHIFTER_CLOCK_50      clock, rising edge
//   SC_RegSHIFTER_RESET_InHigh  asynchronous, active-high reset
//   rand_data_InBUS             random word, new value every clock
//   req_In                      request one sample (level, sampled in IDLE/HOLD)
//   ack_In                      consumer took sample_OutBUS
//   sample_OutBUS               accepted sample, stable while valid
//   sample_valid_Out            sample_OutBUS holds a fresh sample
//   busy_Out                    1 while drawing
//   fallback_Out                current sample came from the fallback path
//   reject_count_OutBUS         (SC_RANDSAMPLER_STATS_EN only) saturating
//                               count of rejected draws, cleared by reset
//
// Optional feature macro: SC_RANDSAMPLER_STATS_EN
module sc_rand_range_sampler #(
  parameter int DATAWIDTH = 8,
  parameter int RANGE     = 160,
  parameter int MAX_TRIES = 16,
  parameter int TRY_W     = 5
) (
  input  logic                 SC_RegSHIFTER_CLOCK_50,
  input  logic                 SC_RegSHIFTER_RESET_InHigh,
  input  logic [DATAWIDTH-1:0] rand_data_InBUS,
  input  logic                 req_In,
  input  logic                 ack_In,
  output logic [DATAWIDTH-1:0] sample_OutBUS,
  output logic                 sample_valid_Out,
  output logic                 busy_Out,
`ifdef SC_RANDSAMPLER_STATS_EN
  output logic [15:0]          reject_count_OutBUS,
`endif
  output logic                 fallback_Out
);

  // RANGE may equal 2^DATAWIDTH, so all range arithmetic is one bit wider.
  localparam logic [DATAWIDTH:0] RANGE_W  = (DATAWIDTH+1)'(RANGE);
  localparam logic [DATAWIDTH:0] RANGE_M1 = RANGE_W - 1'b1;
  localparam logic [TRY_W-1:0]   TRY_LAST = TRY_W'(MAX_TRIES - 1);

  typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [TRY_W-1:0]       tries_q, tries_d;
  logic [DATAWIDTH-1:0]   sample_q, sample_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   fb_q, fb_d;
  logic                   reject;

  logic [DATAWIDTH:0]     rand_w, diff;
  logic                   accept;
  logic [DATAWIDTH-1:0]   fb_val;

  assign rand_w = {1'b0, rand_data_InBUS};
  assign accept = rand_w < RANGE_W;
  // Only evaluated on a reject (rand >= RANGE), so the difference never wraps.
  assign diff   = rand_w - RANGE_W;
  assign fb_val = (diff < RANGE_W) ? diff[DATAWIDTH-1:0] : RANGE_M1[DATAWIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    sample_d = sample_q;
    valid_d  = valid_q;
    fb_d     = fb_q;
    reject   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_In) begin
          state_d = DRAW;
          tries_d = '0;
        end
      end
      DRAW: begin
        if (accept) begin
          sample_d = rand_data_InBUS;
          fb_d     = 1'b0;
          valid_d  = 1'b1;
          state_d  = HOLD;
        end else begin
          reject = 1'b1;
          if (tries_q == TRY_LAST) begin
            sample_d = fb_val;
            fb_d     = 1'b1;
            valid_d  = 1'b1;
            state_d  = HOLD;
          end else begin
            tries_d = tries_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (ack_In) begin
          valid_d = 1'b0;
          if (req_In) begin
            state_d = DRAW;
            tries_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DRAW);
  end

  always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
    if (SC_RegSHIFTER_RESET_InHigh) begin
      state_q  <= IDLE;
      tries_q  <= '0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      fb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tries_q  <= tries_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      fb_q     <= fb_d;
    end
  end

  assign sample_OutBUS    = sample_q;
  assign sample_valid_Out = valid_q;
  assign busy_Out         = busy_q;
  assign fallback_Out     = fb_q;

`ifdef SC_RANDSAMPLER_STATS_EN
  logic [15:0] rej_cnt_q;

  always_ff @(posedge SC_RegSHIFTER_CLOCK_50 or posedge SC_RegSHIFTER_RESET_InHigh) begin
    if (SC_RegSHIFTER_RESET_InHigh)
      rej_cnt_q <= '0;
    else if (reject && rej_cnt_q != 16'hFFFF)
      rej_cnt_q <= rej_cnt_q + 16'd1;
  end

  assign reject_count_OutBUS = rej_cnt_q;
`else
  logic unused_reject;
  assign unused_reject = reject;
`endif

endmodule

// File: tb/tb_sc_rand_range_sampler.sv
// Directed bench for sc_rand_range_sampler (DATAWIDTH=8, RANGE=160,
// MAX_TRIES=16). Inputs change and outputs are sampled 1 ns after each
// rising edge.
module tb_sc_rand_range_sampler;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rnd = 8'h00;
  logic       req = 1'b0;
  logic       ack = 1'b0;
  logic [7:0] sample;
  logic       valid, busy, fb;
`ifdef SC_RANDSAMPLER_STATS_EN
  logic [15:0] rej_cnt;
`endif

  int n_run  = 0;
  int n_fail = 0;

  sc_rand_range_sampler #(.DATAWIDTH(8), .RANGE(160), .MAX_TRIES(16), .TRY_W(5)) dut (
    .SC_RegSHIFTER_CLOCK_50     (clk),
    .SC_RegSHIFTER_RESET_InHigh (rst),
    .rand_data_InBUS            (rnd),
    .req_In                     (req),
    .ack_In                     (ack),
    .sample_OutBUS              (sample),
    .sample_valid_Out           (valid),
    .busy_Out                   (busy),
`ifdef SC_RANDSAMPLER_STATS_EN
    .reject_count_OutBUS        (rej_cnt),
`endif
    .fallback_Out               (fb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse placed between clock edges.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 rst = 1'b0;
  endtask

  initial begin
    #12;
    chk("reset_valid", 32'(valid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_sample", 32'(sample), 0);
    chk("reset_fb", 32'(fb), 0);
    rst = 1'b0;
    step();

    // 1: immediate accept
    req = 1; rnd = 8'h25;
    step();                               // edge 0: IDLE -> DRAW
    chk("t1_busy", 32'(busy), 1);
    chk("t1_valid0", 32'(valid), 0);
    req = 0;
    step();                               // edge 1: accept
    chk("t1_valid", 32'(valid), 1);
    chk("t1_sample", 32'(sample), 32'h25);
    chk("t1_fb", 32'(fb), 0);
    chk("t1_busy_off", 32'(busy), 0);
    step();                               // edge 2: hold
    chk("t1_hold", 32'(valid), 1);
    ack = 1;
    step();                               // edge 3: ack
    chk("t1_ack", 32'(valid), 0);
    chk("t1_idle_sample", 32'(sample), 32'h25);
    ack = 0;

    // 2: A0 boundary reject, C8 reject, 9F accept
    req = 1; rnd = 8'hA0;
    step();
    req = 0;
    step();
    chk("t2_rej1", 32'(valid), 0);
    rnd = 8'hC8;
    step();
    chk("t2_rej2", 32'(valid), 0);
    chk("t2_busy", 32'(busy), 1);
    rnd = 8'h9F;
    step();
    chk("t2_valid", 32'(valid), 1);
    chk("t2_sample", 32'(sample), 32'h9F);
    chk("t2_fb", 32'(fb), 0);
    ack = 1;
    step();
    ack = 0;

    // 3: all rejects -> fallback 0xFF-0xA0 = 0x5F after edge 16
    do_reset();
    step();
    req = 1; rnd = 8'hFF;
    step();                               // edge 0
    req = 0;
    for (int i = 0; i < 15; i++) step();  // edges 1..15
    chk("t3_not_yet", 32'(valid), 0);
    chk("t3_busy", 32'(busy), 1);
    step();                               // edge 16
    chk("t3_valid", 32'(valid), 1);
    chk("t3_sample", 32'(sample), 32'h5F);
    chk("t3_fb", 32'(fb), 1);
    chk("t3_busy_off", 32'(busy), 0);
`ifdef SC_RANDSAMPLER_STATS_EN
    chk("t6_count16", 32'(rej_cnt), 16);
`endif

    // 4: back-to-back req+ack in HOLD
    req = 1; ack = 1;
    step();
    chk("t4_valid", 32'(valid), 0);
    chk("t4_busy", 32'(busy), 1);
    req = 0; ack = 0; rnd = 8'h10;
    step();
    chk("t4_valid2", 32'(valid), 1);
    chk("t4_sample", 32'(sample), 32'h10);
    chk("t4_fb", 32'(fb), 0);

    // 5: async reset mid-DRAW
    ack = 1;
    step();
    ack = 0; req = 1;
    step();
    req = 0; rnd = 8'hFF;
    step();                               // one reject
    chk("t5_busy_pre", 32'(busy), 1);
`ifdef SC_RANDSAMPLER_STATS_EN
    chk("t6_count17", 32'(rej_cnt), 17);
`endif
    #2 rst = 1'b1;
    #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_valid", 32'(valid), 0);
    chk("t5_sample", 32'(sample), 0);
`ifdef SC_RANDSAMPLER_STATS_EN
    chk("t6_count0", 32'(rej_cnt), 0);
`endif
    #1 rst = 1'b0;
    rnd = 8'h01;
    for (int i = 0; i < 3; i++) step();
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_valid", 32'(valid), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
